// File: rtl/sbit_frame_gate.sv
// Per-VFAT S-bit gate: forwards aligned S-bits only after a stable-lock hold-off,
// blocks stuck patterns and keeps saturating hit / re-lock counters.
module sbit_frame_gate #(
  parameter int MXSBITS  = 64,
  parameter int CNT_BITS = 16
) (
  input  logic                clock,
  input  logic                reset_i,
  input  logic [MXSBITS-1:0]  sbits_i,
  input  logic                sot_is_aligned_i,
  input  logic                sot_unstable_i,
  input  logic                mask_i,
  input  logic [11:0]         holdoff_i,
  input  logic [7:0]          stuck_limit_i,
  input  logic                cnt_reset_i,
  output logic [MXSBITS-1:0]  sbits_o,
  output logic                active_o,
  output logic                stuck_o,
  output logic [CNT_BITS-1:0] hit_count_o,
  output logic [7:0]          relock_count_o
);

  typedef enum logic [1:0] {IDLE, HOLDOFF, ACTIVE, STUCK} state_t;

  state_t              state_q, state_d;
  logic [11:0]         timer_q, timer_d;
  logic [7:0]          run_q, run_d, run_nxt;
  logic [MXSBITS-1:0]  prev_q, prev_d;
  logic [MXSBITS-1:0]  sbits_q, sbits_d;
  logic                active_q, active_d;
  logic                stuck_q, stuck_d;
  logic [CNT_BITS-1:0] hit_q, hit_d;
  logic [7:0]          relock_q, relock_d;
  logic                lock_ok, stuck_det, relock_inc;

  always_comb begin
    lock_ok    = sot_is_aligned_i && !sot_unstable_i && !mask_i;
    state_d    = state_q;
    timer_d    = timer_q;
    run_d      = '0;
    relock_inc = 1'b0;
    prev_d     = sbits_i;

    if (sbits_i != '0 && sbits_i == prev_q)
      run_nxt = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    else
      run_nxt = (sbits_i != '0) ? 8'd1 : 8'd0;

    stuck_det = (state_q == ACTIVE) && (stuck_limit_i != '0) && (run_nxt == stuck_limit_i);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (lock_ok) begin
          if (holdoff_i == '0) state_d = ACTIVE;
          else begin
            state_d = HOLDOFF;
            timer_d = 12'd1;
          end
        end
      end
      HOLDOFF: begin
        if (!lock_ok) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == holdoff_i) begin
          state_d = ACTIVE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 12'd1;
        end
      end
      ACTIVE: begin
        run_d = run_nxt;
        // Mask outranks alignment loss so a deliberate mask never counts as a re-lock.
        if (mask_i) begin
          state_d = IDLE;
          run_d   = '0;
        end else if (!sot_is_aligned_i || sot_unstable_i) begin
          state_d    = IDLE;
          run_d      = '0;
          relock_inc = 1'b1;
        end else if (stuck_det) begin
          state_d = STUCK;
          run_d   = '0;
        end
      end
      STUCK: begin
        if (mask_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sbits_d  = (state_q == ACTIVE && lock_ok && !stuck_det) ? sbits_i : '0;
    active_d = (state_d == ACTIVE);
    stuck_d  = (state_d == STUCK);

    hit_d = hit_q;
    if (cnt_reset_i)                             hit_d = '0;
    else if (sbits_d != '0 && hit_q != '1)       hit_d = hit_q + CNT_BITS'(1);

    relock_d = relock_q;
    if (cnt_reset_i)                             relock_d = '0;
    else if (relock_inc && relock_q != 8'hFF)    relock_d = relock_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      run_q    <= '0;
      prev_q   <= '0;
      sbits_q  <= '0;
      active_q <= 1'b0;
      stuck_q  <= 1'b0;
      hit_q    <= '0;
      relock_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      run_q    <= run_d;
      prev_q   <= prev_d;
      sbits_q  <= sbits_d;
      active_q <= active_d;
      stuck_q  <= stuck_d;
      hit_q    <= hit_d;
      relock_q <= relock_d;
    end
  end

  assign sbits_o        = sbits_q;
  assign active_o       = active_q;
  assign stuck_o        = stuck_q;
  assign hit_count_o    = hit_q;
  assign relock_count_o = relock_q;

endmodule
